// File: rtl/vdic_mult_arbiter.sv
// Two-requester round-robin arbiter in front of a single 16x16 signed multiplier.
// Optional watchdog on m_ack / m_result_rdy enabled by defining VDIC_ARB_TIMEOUT_EN.
module vdic_mult_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_req,
    input  logic [15:0] s0_arg_a,
    input  logic        s0_arg_a_parity,
    input  logic [15:0] s0_arg_b,
    input  logic        s0_arg_b_parity,
    input  logic        s1_req,
    input  logic [15:0] s1_arg_a,
    input  logic        s1_arg_a_parity,
    input  logic [15:0] s1_arg_b,
    input  logic        s1_arg_b_parity,
    output logic        s0_ack,
    output logic [31:0] s0_result,
    output logic        s0_result_parity,
    output logic        s0_result_rdy,
    output logic        s0_arg_parity_error,
    output logic        s1_ack,
    output logic [31:0] s1_result,
    output logic        s1_result_parity,
    output logic        s1_result_rdy,
    output logic        s1_arg_parity_error,
    output logic        m_rst_n,
    output logic        m_req,
    output logic [15:0] m_arg_a,
    output logic [15:0] m_arg_b,
    output logic        m_arg_a_parity,
    output logic        m_arg_b_parity,
    input  logic        m_ack,
    input  logic [31:0] m_result,
    input  logic        m_result_parity,
    input  logic        m_result_rdy,
    input  logic        m_arg_parity_error,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2
    } state_t;

    state_t      state_r, state_next_s;
    logic        grant_r, grant_next_s;
    logic        rr_prio_r;
    logic        start_s, accept_s, done_s, timeout_s;

    logic [15:0] op_a_r, op_b_r;
    logic        op_a_par_r, op_b_par_r;
    logic        m_req_r, m_rst_n_r, timeout_err_r;
    logic        s0_ack_r, s1_ack_r, s0_rdy_r, s1_rdy_r;
    logic [31:0] s0_res_r, s1_res_r;
    logic        s0_res_par_r, s1_res_par_r, s0_perr_r, s1_perr_r;

`ifdef VDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_r;

    // Watchdog counter: restarts on every state entry, idles at zero.
    always_ff @(posedge clk) begin
        if (rst || start_s || accept_s || (state_r == ST_IDLE)) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // A strobe arriving on the limit cycle still wins over the timeout.
    assign timeout_s = (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                       (((state_r == ST_ISSUE)    && !m_ack) ||
                        ((state_r == ST_WAIT_RES) && !m_result_rdy));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        start_s      = 1'b0;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s0_req && s1_req) begin
                    grant_next_s = rr_prio_r;
                    start_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else if (s0_req || s1_req) begin
                    grant_next_s = s1_req;
                    start_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_ack) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_WAIT_RES;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT_RES: begin
                if (m_result_rdy) begin
                    done_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_RES;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Grant owner and round-robin pointer (pointer names who wins a tie).
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r   <= 1'b0;
            rr_prio_r <= 1'b0;
        end else if (start_s) begin
            grant_r   <= grant_next_s;
            rr_prio_r <= ~grant_next_s;
        end else begin
            grant_r   <= grant_r;
            rr_prio_r <= rr_prio_r;
        end
    end

    // Operand latch, multiplier handshake and per-channel result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r        <= 16'h0000;
            op_b_r        <= 16'h0000;
            op_a_par_r    <= 1'b0;
            op_b_par_r    <= 1'b0;
            m_req_r       <= 1'b0;
            m_rst_n_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            s0_ack_r      <= 1'b0;
            s1_ack_r      <= 1'b0;
            s0_rdy_r      <= 1'b0;
            s1_rdy_r      <= 1'b0;
            s0_res_r      <= 32'h0000_0000;
            s1_res_r      <= 32'h0000_0000;
            s0_res_par_r  <= 1'b0;
            s1_res_par_r  <= 1'b0;
            s0_perr_r     <= 1'b0;
            s1_perr_r     <= 1'b0;
        end else begin
            m_rst_n_r     <= ~timeout_s;
            timeout_err_r <= timeout_s;
            s0_ack_r      <= 1'b0;
            s1_ack_r      <= 1'b0;
            s0_rdy_r      <= 1'b0;
            s1_rdy_r      <= 1'b0;
            if (start_s) begin
                op_a_r     <= grant_next_s ? s1_arg_a : s0_arg_a;
                op_b_r     <= grant_next_s ? s1_arg_b : s0_arg_b;
                op_a_par_r <= grant_next_s ? s1_arg_a_parity : s0_arg_a_parity;
                op_b_par_r <= grant_next_s ? s1_arg_b_parity : s0_arg_b_parity;
                m_req_r    <= 1'b1;
            end else if (accept_s) begin
                m_req_r  <= 1'b0;
                s0_ack_r <= ~grant_r;
                s1_ack_r <= grant_r;
            end else if (done_s) begin
                if (grant_r) begin
                    s1_res_r     <= m_result;
                    s1_res_par_r <= m_result_parity;
                    s1_perr_r    <= m_arg_parity_error;
                    s1_rdy_r     <= 1'b1;
                end else begin
                    s0_res_r     <= m_result;
                    s0_res_par_r <= m_result_parity;
                    s0_perr_r    <= m_arg_parity_error;
                    s0_rdy_r     <= 1'b1;
                end
            end else if (timeout_s) begin
                // Abandoned transaction completes toward the requester as a parity error.
                m_req_r  <= 1'b0;
                s0_ack_r <= ~grant_r && (state_r == ST_ISSUE);
                s1_ack_r <= grant_r && (state_r == ST_ISSUE);
                if (grant_r) begin
                    s1_res_r     <= 32'h0000_0000;
                    s1_res_par_r <= 1'b0;
                    s1_perr_r    <= 1'b1;
                    s1_rdy_r     <= 1'b1;
                end else begin
                    s0_res_r     <= 32'h0000_0000;
                    s0_res_par_r <= 1'b0;
                    s0_perr_r    <= 1'b1;
                    s0_rdy_r     <= 1'b1;
                end
            end else begin
                m_req_r <= m_req_r;
            end
        end
    end

    assign m_rst_n             = m_rst_n_r;
    assign m_req               = m_req_r;
    assign m_arg_a             = op_a_r;
    assign m_arg_b             = op_b_r;
    assign m_arg_a_parity      = op_a_par_r;
    assign m_arg_b_parity      = op_b_par_r;
    assign timeout_err         = timeout_err_r;
    assign s0_ack              = s0_ack_r;
    assign s1_ack              = s1_ack_r;
    assign s0_result_rdy       = s0_rdy_r;
    assign s1_result_rdy       = s1_rdy_r;
    assign s0_result           = s0_res_r;
    assign s1_result           = s1_res_r;
    assign s0_result_parity    = s0_res_par_r;
    assign s1_result_parity    = s1_res_par_r;
    assign s0_arg_parity_error = s0_perr_r;
    assign s1_arg_parity_error = s1_perr_r;

endmodule

// File: tb/tb_vdic_mult_arbiter.sv
// Directed self-checking bench for vdic_mult_arbiter; the bench plays the multiplier.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vdic_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic [15:0] s0_arg_a = 16'h0000, s0_arg_b = 16'h0000;
    logic [15:0] s1_arg_a = 16'h0000, s1_arg_b = 16'h0000;
    logic        s0_arg_a_parity = 1'b0, s0_arg_b_parity = 1'b0;
    logic        s1_arg_a_parity = 1'b0, s1_arg_b_parity = 1'b0;
    logic        s0_ack, s1_ack, s0_result_rdy, s1_result_rdy;
    logic [31:0] s0_result, s1_result;
    logic        s0_result_parity, s1_result_parity;
    logic        s0_arg_parity_error, s1_arg_parity_error;
    logic        m_rst_n, m_req, m_arg_a_parity, m_arg_b_parity;
    logic [15:0] m_arg_a, m_arg_b;
    logic        m_ack = 1'b0, m_result_rdy = 1'b0;
    logic [31:0] m_result = 32'h0000_0000;
    logic        m_result_parity = 1'b0, m_arg_parity_error = 1'b0;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    vdic_mult_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_arg_a(s0_arg_a), .s0_arg_a_parity(s0_arg_a_parity),
        .s0_arg_b(s0_arg_b), .s0_arg_b_parity(s0_arg_b_parity),
        .s1_req(s1_req), .s1_arg_a(s1_arg_a), .s1_arg_a_parity(s1_arg_a_parity),
        .s1_arg_b(s1_arg_b), .s1_arg_b_parity(s1_arg_b_parity),
        .s0_ack(s0_ack), .s0_result(s0_result), .s0_result_parity(s0_result_parity),
        .s0_result_rdy(s0_result_rdy), .s0_arg_parity_error(s0_arg_parity_error),
        .s1_ack(s1_ack), .s1_result(s1_result), .s1_result_parity(s1_result_parity),
        .s1_result_rdy(s1_result_rdy), .s1_arg_parity_error(s1_arg_parity_error),
        .m_rst_n(m_rst_n), .m_req(m_req), .m_arg_a(m_arg_a), .m_arg_b(m_arg_b),
        .m_arg_a_parity(m_arg_a_parity), .m_arg_b_parity(m_arg_b_parity),
        .m_ack(m_ack), .m_result(m_result), .m_result_parity(m_result_parity),
        .m_result_rdy(m_result_rdy), .m_arg_parity_error(m_arg_parity_error),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one transaction for requester g whose req is already (or about to be) seen.
    task automatic txn(input int g, input logic [15:0] a, input logic [15:0] b,
                       input logic pa, input logic pb, input logic [31:0] res,
                       input logic perr, input bit keep, input bit stray, output int latency);
        latency = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!m_req && latency < 10);
        chk("m_req_seen", {31'd0, m_req}, 32'd1);
        chk("m_arg_a", {16'd0, m_arg_a}, {16'd0, a});
        chk("m_arg_b", {16'd0, m_arg_b}, {16'd0, b});
        chk("m_arg_par", {30'd0, m_arg_a_parity, m_arg_b_parity}, {30'd0, pa, pb});
        if (stray) begin
            m_result_rdy = 1'b1;
            @(negedge clk);
            m_result_rdy = 1'b0;
            chk("stray_rdy_ignored", {30'd0, s1_result_rdy, s0_result_rdy}, 32'd0);
            chk("stray_m_req_held", {31'd0, m_req}, 32'd1);
        end
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("ack_pulse", {30'd0, s1_ack, s0_ack}, (g == 1) ? 32'd2 : 32'd1);
        chk("m_req_dropped", {31'd0, m_req}, 32'd0);
        if (!keep) begin
            if (g == 1) s1_req = 1'b0; else s0_req = 1'b0;
        end
        m_result = res;
        m_result_parity = ^res;
        m_arg_parity_error = perr;
        m_result_rdy = 1'b1;
        @(negedge clk);
        m_result_rdy = 1'b0;
        chk("ack_one_cycle", {30'd0, s1_ack, s0_ack}, 32'd0);
        chk("rdy_pulse", {30'd0, s1_result_rdy, s0_result_rdy}, (g == 1) ? 32'd2 : 32'd1);
        chk("result", (g == 1) ? s1_result : s0_result, res);
        chk("result_par", {31'd0, (g == 1) ? s1_result_parity : s0_result_parity}, {31'd0, ^res});
        chk("arg_perr", {31'd0, (g == 1) ? s1_arg_parity_error : s0_arg_parity_error}, {31'd0, perr});
        @(negedge clk);
        chk("rdy_one_cycle", {30'd0, s1_result_rdy, s0_result_rdy}, 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_m_rst_n", {31'd0, m_rst_n}, 32'd0);
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_results", s0_result | s1_result, 32'd0);
        chk("rst_flags", {26'd0, s0_ack, s1_ack, s0_result_rdy, s1_result_rdy,
                          s0_arg_parity_error, timeout_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("m_rst_n_release", {31'd0, m_rst_n}, 32'd1);

        // Stray m_ack in IDLE does nothing.
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("idle_ack_ignored", {29'd0, m_req, s0_ack, s1_ack}, 32'd0);

        // s0 only: 3 * -4 = -12.
        s0_req = 1'b1; s0_arg_a = 16'h0003; s0_arg_b = 16'hFFFC;
        s0_arg_a_parity = 1'b0; s0_arg_b_parity = 1'b0;
        txn(0, 16'h0003, 16'hFFFC, 1'b0, 1'b0, 32'hFFFF_FFF4, 1'b0, 1'b0, 1'b0, lat);
        chk("req_latency", lat, 32'd1);
        chk("s0_neg12_par", {31'd0, s0_result_parity}, 32'd1);

        // Re-reset so the round-robin pointer returns to s0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Both requesters keep re-requesting: grants must alternate 0,1,0,1.
        s0_req = 1'b1; s0_arg_a = 16'd100;  s0_arg_b = 16'hFFF9; s0_arg_a_parity = 1'b1;
        s1_req = 1'b1; s1_arg_a = 16'hFFFE; s1_arg_b = 16'hFFF7; s1_arg_b_parity = 1'b1;
        txn(0, 16'd100, 16'hFFF9, 1'b1, 1'b0, 32'hFFFF_FD44, 1'b0, 1'b1, 1'b0, lat);
        txn(1, 16'hFFFE, 16'hFFF7, 1'b0, 1'b1, 32'h0000_0012, 1'b0, 1'b1, 1'b0, lat);
        txn(0, 16'd100, 16'hFFF9, 1'b1, 1'b0, 32'hFFFF_FD44, 1'b0, 1'b0, 1'b0, lat);
        txn(1, 16'hFFFE, 16'hFFF7, 1'b0, 1'b1, 32'h0000_0012, 1'b0, 1'b0, 1'b0, lat);
        chk("s0_after_rr", s0_result, 32'hFFFF_FD44);

        // s1 with bad A parity; multiplier flags it and returns 0. Stray rdy in ISSUE.
        s1_req = 1'b1; s1_arg_a = 16'h7FFF; s1_arg_b = 16'h8000;
        s1_arg_a_parity = 1'b0; s1_arg_b_parity = 1'b1;
        txn(1, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, lat);
        chk("s0_unchanged_res", s0_result, 32'hFFFF_FD44);
        chk("s0_unchanged_perr", {31'd0, s0_arg_parity_error}, 32'd0);

        // Reset while waiting for the result aborts the transaction.
        s0_req = 1'b1; s0_arg_a = 16'd9; s0_arg_b = 16'd9; s0_arg_a_parity = 1'b0;
        @(negedge clk);
        chk("abort_m_req", {31'd0, m_req}, 32'd1);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0; s0_req = 1'b0;
        chk("abort_ack", {31'd0, s0_ack}, 32'd1);
        rst = 1'b1; m_result = 32'd81; m_result_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_result_rdy = 1'b0;
        chk("abort_no_rdy", {30'd0, s0_result_rdy, s1_result_rdy}, 32'd0);
        chk("abort_results", s0_result | s1_result, 32'd0);
        chk("abort_perr", {30'd0, s0_arg_parity_error, s1_arg_parity_error}, 32'd0);
        chk("abort_m_rst_n", {31'd0, m_rst_n}, 32'd0);
        @(negedge clk);
        chk("abort_m_rst_n_rel", {31'd0, m_rst_n}, 32'd1);
        chk("abort_still_no_rdy", {31'd0, s0_result_rdy}, 32'd0);
        s1_req = 1'b1; s1_arg_a = 16'hFFFD; s1_arg_b = 16'd7;
        s1_arg_a_parity = 1'b1; s1_arg_b_parity = 1'b1;
        txn(1, 16'hFFFD, 16'd7, 1'b1, 1'b1, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, lat);

        // Multiplier never returns a result.
        s0_req = 1'b1; s0_arg_a = 16'd2; s0_arg_b = 16'd2; s0_arg_b_parity = 1'b0;
        @(negedge clk);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0; s0_req = 1'b0;
        chk("wd_ack", {31'd0, s0_ack}, 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s0_result_rdy && !timeout_err && lat < 80);
`ifdef VDIC_ARB_TIMEOUT_EN
        chk("wd_cycles", lat, 32'd64);
        chk("wd_flags", {29'd0, timeout_err, s0_result_rdy, m_rst_n}, 32'd6);
        chk("wd_result", s0_result, 32'd0);
        chk("wd_perr", {31'd0, s0_arg_parity_error}, 32'd1);
        @(negedge clk);
        chk("wd_pulse_end", {29'd0, timeout_err, s0_result_rdy, m_rst_n}, 32'd1);
`else
        chk("no_wd_wait", lat, 32'd80);
        chk("no_wd_flags", {30'd0, timeout_err, s0_result_rdy}, 32'd0);
        m_result = 32'd4; m_result_parity = 1'b1; m_arg_parity_error = 1'b0;
        m_result_rdy = 1'b1;
        @(negedge clk);
        m_result_rdy = 1'b0;
        chk("late_rdy", {31'd0, s0_result_rdy}, 32'd1);
        chk("late_result", s0_result, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
